// File: rtl/mem_stage_unit.sv
// mem_stage_unit: MEM pipeline stage.
// Consumes the EX/MEM register and performs loads/stores on an external data
// memory over a req/ack handshake. While an access is in flight the front of
// the pipeline is stalled and bubbles are written into MEM/WB. Misaligned
// accesses and bus timeouts suppress the register writeback. Branch
// resolution (pc_src/pc_target) is a pure pass-through of EX/MEM.
module mem_stage_unit #(
  parameter int DATA_W  = 64,
  parameter int RD_W    = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              em_Branch,
  input  logic              em_branch_op,
  input  logic              em_MemRead,
  input  logic              em_MemWrite,
  input  logic              em_MemtoReg,
  input  logic              em_RegWrite,
  input  logic [RD_W-1:0]   em_rd,
  input  logic [DATA_W-1:0] em_Result,
  input  logic [DATA_W-1:0] em_WriteData,
  input  logic [DATA_W-1:0] em_target,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              pc_src,
  output logic [DATA_W-1:0] pc_target,
  output logic              mw_RegWrite,
  output logic              mw_MemtoReg,
  output logic [RD_W-1:0]   mw_rd,
  output logic [DATA_W-1:0] mw_ReadData,
  output logic [DATA_W-1:0] mw_ALUResult,
  output logic              misalign_err,
  output logic              bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;
  logic [DATA_W-1:0]  r_rdata;

  logic               w_acc;
  logic               w_mis;
  logic               w_issue;
  logic               w_timeout;
  logic               w_stall;
  logic               w_is_load;

  assign w_acc     = em_MemRead | em_MemWrite;
  // Doubleword accesses must sit on an 8-byte boundary.
  assign w_mis     = w_acc & (em_Result[2:0] != 3'd0);
  assign w_issue   = (r_state == ST_IDLE) & w_acc & ~w_mis;
  assign w_timeout = (r_state == ST_WAIT) & ~mem_ack & (r_cnt == CNT_W'(TIMEOUT - 1));
  // A store wins when both MemRead and MemWrite are set.
  assign w_is_load = em_MemRead & ~em_MemWrite;

  // Branch resolution never waits on memory; EX/MEM is frozen during a stall.
  assign pc_src    = em_Branch & em_branch_op;
  assign pc_target = em_target;

  // Reset abandons any access and releases the pipeline immediately.
  assign stall = w_stall & ~reset;

  // Next-state and stall decode.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_issue) begin
          w_stall = 1'b1;
          w_next  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_stall = 1'b1;
        if (mem_ack || w_timeout) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Memory bus request, wait counter, load-data latch and error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            mem_req   <= 1'b1;
            mem_we    <= em_MemWrite;
            mem_addr  <= em_Result;
            mem_wdata <= em_WriteData;
            r_cnt     <= '0;
          end
        end
        ST_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            r_rdata <= mem_we ? '0 : mem_rdata;
          end else if (w_timeout) begin
            mem_req <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: r_err <= 1'b0;
        default: ;
      endcase
    end
  end

  // One-cycle error pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      misalign_err <= (r_state == ST_IDLE) & w_mis;
      bus_err      <= w_timeout;
    end
  end

  // MEM/WB register: bubble while stalled, otherwise capture the instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mw_RegWrite  <= 1'b0;
      mw_MemtoReg  <= 1'b0;
      mw_rd        <= '0;
      mw_ReadData  <= '0;
      mw_ALUResult <= '0;
    end else if (w_stall) begin
      mw_RegWrite  <= 1'b0;
      mw_MemtoReg  <= 1'b0;
      mw_rd        <= '0;
      mw_ReadData  <= '0;
      mw_ALUResult <= '0;
    end else begin
      mw_RegWrite  <= em_RegWrite & ~w_mis & ~r_err;
      mw_MemtoReg  <= em_MemtoReg;
      mw_rd        <= em_rd;
      mw_ALUResult <= em_Result;
      mw_ReadData  <= ((r_state == ST_DONE) && w_is_load) ? r_rdata : '0;
    end
  end

endmodule
